// File: rtl/rgb_led_pwm_driver.sv
// Turns per-channel RGB enable bits into brightness-controlled PWM pin drive, with an optional breathing envelope.
// Latency: led_out lags pwm_cnt by one cycle; all inputs take effect at the next period wrap; free-running, no backpressure.
module rgb_led_pwm_driver #(
    parameter int NUM_LED      = 4,
    parameter int PRESCALE_DIV = 64,
    parameter int BREATHE_STEP = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [3*NUM_LED-1:0]   led_in,
    input  logic [7:0]             brightness,
    input  logic                   breathe_en,
    output logic [3*NUM_LED-1:0]   led_out,
    output logic                   period_start
);

    localparam int  NCH = 3 * NUM_LED;
    localparam logic AL = (ACTIVE_LOW != 0);

    logic [15:0]    r_prescaler;
    logic [7:0]     r_pwm_cnt;
    logic [7:0]     r_env;
    logic           r_env_down;
    logic [7:0]     r_duty_lat;
    logic [NCH-1:0] r_col_lat;

    logic           w_tick;
    logic           w_wrap;
    logic [NCH-1:0] w_lit;
    logic [7:0]     w_duty_brth;
    logic [8:0]     w_env_up;
    logic [8:0]     w_env_dn;
    logic [7:0]     w_env_nxt;
    logic           w_env_down_nxt;

    assign w_tick = (r_prescaler == 16'(PRESCALE_DIV - 1));
    assign w_wrap = w_tick && (r_pwm_cnt == 8'hFF);
    assign w_lit  = (r_pwm_cnt < r_duty_lat) ? r_col_lat : '0;

    // Upper byte of the 16-bit product; truncation, never rounding.
    assign w_duty_brth = 8'((16'(brightness) * 16'(r_env)) >> 8);

    assign w_env_up = {1'b0, r_env} + 9'(BREATHE_STEP);
    assign w_env_dn = {1'b0, r_env} - 9'(BREATHE_STEP);

    // Saturating triangle: bit 8 of the down result flags an underflow.
    always_comb begin
        w_env_nxt      = 8'h00;
        w_env_down_nxt = 1'b0;
        if (breathe_en) begin
            if (!r_env_down) begin
                if (w_env_up >= 9'd255) begin
                    w_env_nxt      = 8'hFF;
                    w_env_down_nxt = 1'b1;
                end else begin
                    w_env_nxt      = w_env_up[7:0];
                    w_env_down_nxt = 1'b0;
                end
            end else begin
                if (w_env_dn[8] || (w_env_dn == 9'd0)) begin
                    w_env_nxt      = 8'h00;
                    w_env_down_nxt = 1'b0;
                end else begin
                    w_env_nxt      = w_env_dn[7:0];
                    w_env_down_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_prescaler  <= '0;
            r_pwm_cnt    <= '0;
            r_env        <= '0;
            r_env_down   <= 1'b0;
            r_duty_lat   <= '0;
            r_col_lat    <= '0;
            led_out      <= {NCH{AL}};
            period_start <= 1'b0;
        end else begin
            r_prescaler  <= w_tick ? 16'd0 : r_prescaler + 16'd1;
            period_start <= w_wrap;
            led_out      <= AL ? ~w_lit : w_lit;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
            // Everything that shapes a period is captured only at the wrap.
            if (w_wrap) begin
                r_col_lat  <= led_in;
                r_duty_lat <= breathe_en ? w_duty_brth : brightness;
                r_env      <= w_env_nxt;
                r_env_down <= w_env_down_nxt;
            end
        end
    end

endmodule

// File: tb/tb_rgb_led_pwm_driver.sv
// Bench for rgb_led_pwm_driver: two instances (fast active-low, prescaled active-high) against a time-indexed model.
module tb_rgb_led_pwm_driver;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [11:0] led_in;
    logic [7:0]  brightness;
    logic        breathe_en;
    logic [11:0] led_out_a, led_out_b;
    logic        ps_a, ps_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_clk = ~clk_clk;

    rgb_led_pwm_driver #(.NUM_LED(4), .PRESCALE_DIV(1), .BREATHE_STEP(64), .ACTIVE_LOW(1)) u_a (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .led_in(led_in), .brightness(brightness),
        .breathe_en(breathe_en), .led_out(led_out_a), .period_start(ps_a));

    rgb_led_pwm_driver #(.NUM_LED(4), .PRESCALE_DIV(3), .BREATHE_STEP(4), .ACTIVE_LOW(0)) u_b (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .led_in(led_in), .brightness(brightness),
        .breathe_en(breathe_en), .led_out(led_out_b), .period_start(ps_b));

    // Model: n counts clock edges since reset release, so the position in the
    // period is (n mod 256*DIV) and the PWM step is that position / DIV.
    int          m_n[2];
    int          m_env[2];
    bit          m_dn[2];
    int          m_duty[2];
    logic [11:0] m_col[2];
    logic [11:0] m_led[2];
    logic        m_ps[2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction
    function automatic int step_of(input int i);
        return (i == 0) ? 64 : 4;
    endfunction
    function automatic bit al_of(input int i);
        return (i == 0);
    endfunction

    task automatic model_edge(input int i);
        int period, p, cnt, e;
        logic [11:0] lit;
        if (reset_reset) begin
            m_n[i] = 0; m_env[i] = 0; m_dn[i] = 0; m_duty[i] = 0; m_col[i] = '0;
            m_led[i] = al_of(i) ? 12'hFFF : 12'h000;
            m_ps[i] = 1'b0;
            return;
        end
        period   = 256 * div_of(i);
        p        = m_n[i] % period;
        cnt      = p / div_of(i);
        lit      = (cnt < m_duty[i]) ? m_col[i] : 12'h000;
        m_led[i] = al_of(i) ? ~lit : lit;
        m_ps[i]  = (p == period - 1);
        if (p == period - 1) begin
            m_col[i]  = led_in;
            m_duty[i] = breathe_en ? (int'(brightness) * m_env[i]) / 256 : int'(brightness);
            if (!breathe_en) begin
                m_env[i] = 0; m_dn[i] = 0;
            end else if (!m_dn[i]) begin
                e = m_env[i] + step_of(i);
                if (e >= 255) begin e = 255; m_dn[i] = 1; end
                m_env[i] = e;
            end else begin
                e = m_env[i] - step_of(i);
                if (e <= 0) begin e = 0; m_dn[i] = 0; end
                m_env[i] = e;
            end
        end
        m_n[i]++;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_eq("led_a", led_out_a, m_led[0]);
        check_eq("ps_a",  ps_a,      m_ps[0]);
        check_eq("led_b", led_out_b, m_led[1]);
        check_eq("ps_b",  ps_b,      m_ps[1]);
    endtask

    task automatic wait_ps();
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!ps_a && k < 600);
        check_eq("wait_ps", ps_a, 1);
    endtask

    // One full period of instance a, counting lit (low) cycles on bits 0..2.
    int w_low0, w_low1, w_low2;
    task automatic run_window(input int chg_at, input logic [7:0] brt_new);
        w_low0 = 0; w_low1 = 0; w_low2 = 0;
        for (int j = 0; j < 256; j++) begin
            if (j == chg_at) brightness = brt_new;
            cyc();
            if (!led_out_a[0]) w_low0++;
            if (!led_out_a[1]) w_low1++;
            if (!led_out_a[2]) w_low2++;
        end
        check_eq("ps_period", ps_a, 1);
    endtask

    int exp_breathe[10] = '{0, 63, 127, 191, 254, 190, 126, 62, 0, 63};
    int ps_cnt;

    initial begin
        reset_reset = 1'b1;
        led_in      = 12'h005;
        brightness  = 8'd64;
        breathe_en  = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        check_eq("rst_led_a", led_out_a, 12'hFFF);
        check_eq("rst_led_b", led_out_b, 12'h000);
        reset_reset = 1'b0;

        ps_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            cyc();
            if (ps_a) ps_cnt++;
            if (led_out_a != 12'hFFF) ps_cnt++;
        end
        check_eq("quiet_after_rst", ps_cnt, 0);
        cyc();
        check_eq("first_ps", ps_a, 1);

        run_window(-1, 8'd64);
        check_eq("b64_red", w_low0, 64);
        check_eq("b64_green", w_low1, 0);
        check_eq("b64_blue", w_low2, 64);

        brightness = 8'd0;
        wait_ps();
        run_window(-1, 8'd0);
        check_eq("b0_red", w_low0, 0);

        brightness = 8'd255;
        wait_ps();
        run_window(-1, 8'd0);
        check_eq("b255_red", w_low0, 255);
        check_eq("b255_blue", w_low2, 255);

        brightness = 8'd64;
        wait_ps();
        run_window(100, 8'd128);
        check_eq("midchg_cur", w_low0, 64);
        run_window(-1, 8'd0);
        check_eq("midchg_next", w_low0, 128);

        led_in     = 12'hFFF;
        brightness = 8'd255;
        breathe_en = 1'b1;
        wait_ps();
        for (int k = 0; k < 10; k++) begin
            run_window(-1, 8'd0);
            check_eq($sformatf("breathe_%0d", k), w_low0, exp_breathe[k]);
        end

        breathe_en = 1'b0;
        brightness = 8'd128;
        wait_ps();
        wait_ps();
        for (int i = 0; i < 50; i++) cyc();
        check_eq("lit_before_rst", led_out_a, 12'h000);
        reset_reset = 1'b1;
        cyc();
        check_eq("rst_pulse_led", led_out_a, 12'hFFF);
        reset_reset = 1'b0;
        ps_cnt = 0;
        do begin
            cyc();
            ps_cnt++;
        end while (!ps_a && ps_cnt < 1000);
        check_eq("edges_rst_to_ps", ps_cnt, 256);

        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                led_in     = 12'($urandom);
                brightness = 8'($urandom_range(0, 255));
                breathe_en = 1'($urandom_range(0, 1));
            end
            reset_reset = ($urandom_range(0, 2999) == 0);
            cyc();
        end
        reset_reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
